// File: rtl/fetch.sv
// Instruction fetch front end: drives the synchronous instruction memory and
// holds fetched bytes in a small prefetch buffer presented to decode.
module fetch #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       async_rst,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  input  logic       stall_en,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic [7:0] opcode,
  output logic       opcode_valid,
  output logic [7:0] opcode_pc
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic          discard_q, discard_d;

  logic [DW-1:0] buf_data_q [DEPTH];
  logic [AW-1:0] buf_pc_q   [DEPTH];

  logic          pop;
  logic          wr;
  logic          req;
  logic [OW-1:0] occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy after this cycle's pop, counting the read already in flight.
  always_comb begin
    pop = (count_q != '0) & ~stall_en & ~redirect;
    occ = OW'(count_q) + OW'(inflight_q) - OW'(pop);
    req = ~async_rst & ~redirect & (occ < OW'(DEPTH));
    wr  = inflight_q & ~discard_q & ~redirect;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    inflight_d    = req;
    inflight_pc_d = fetch_pc_q;
    discard_d     = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      head_d     = tail_q;
      count_d    = '0;
      discard_d  = req;
    end else begin
      if (req) fetch_pc_d = fetch_pc_q + AW'(1);
      if (pop) head_d = ptr_inc(head_q);
      if (wr)  tail_d = ptr_inc(tail_q);
      count_d = count_q + CW'(wr) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      fetch_pc_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      discard_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      discard_q     <= discard_d;
    end
  end

  // Prefetch storage; a response lands at the tail tagged with its request address.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else if (wr) begin
      buf_data_q[tail_q] <= imem_data;
      buf_pc_q[tail_q]   <= inflight_pc_q;
    end
  end

  assign imem_req     = req;
  assign imem_addr    = fetch_pc_q;
  assign opcode       = buf_data_q[head_q];
  assign opcode_pc    = buf_pc_q[head_q];
  assign opcode_valid = (count_q != '0);

  a_count_bound : assert property (@(posedge clk) disable iff (async_rst)
    count_q <= CW'(DEPTH));

endmodule
